// File: rtl/dac_sample_scheduler_if.sv
// Receive-side bus from the deserializer into the DAC sample scheduler.
// rx_valid is a one-cycle strobe qualifying rx_data.
interface dac_sample_scheduler_if #(
  parameter int D_W = 8
) ();
  logic [D_W-1:0] rx_data;
  logic           rx_valid;

  modport master (
    output rx_data,
    output rx_valid
  );

  modport slave (
    input rx_data,
    input rx_valid
  );
endinterface

// File: rtl/dac_sample_scheduler.sv
// Buffers deserialized words in a FIFO and releases them to the R2R DAC code
// register at a fixed, programmable sample rate, with priming and sticky error flags.
module dac_sample_scheduler #(
  parameter int D_W       = 8,
  parameter int DEPTH     = 8,
  parameter int DIV_W     = 16,
  parameter int PRIME_LVL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  dac_sample_scheduler_if.slave  rx_if,
  input  logic [DIV_W-1:0]       cfg_div_i,
  input  logic                   clear_flags_i,
  output logic [D_W-1:0]         dac_code_o,
  output logic                   dac_update_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic                   running_o,
  output logic                   underrun_o,
  output logic                   overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FullLvl  = LW'(DEPTH);
  localparam logic [LW-1:0] PrimeLvl = LW'(PRIME_LVL);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [D_W-1:0]   code_q, code_d;
  logic             update_q, update_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;
  logic [D_W-1:0]   mem_q [DEPTH];

  logic tick;
  logic pop;
  logic push;
  logic underrunSet;
  logic overflowSet;

  // A tick in the cycle enable drops is ignored so a disable never consumes a sample.
  assign tick        = (state_q == RUN) && enable_i && (count_q == cfg_div_i);
  assign pop         = tick && (level_q != '0);
  assign push        = rx_if.rx_valid && ((level_q != FullLvl) || pop);
  assign underrunSet = tick && (level_q == '0);
  assign overflowSet = rx_if.rx_valid && !push;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    code_d     = code_q;
    update_d   = pop;
    underrun_d = underrunSet | (underrun_q & ~clear_flags_i);
    overflow_d = overflowSet | (overflow_q & ~clear_flags_i);

    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
      code_d  = mem_q[rdPtr_q];
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable_i) begin
          state_d = PRIME;
        end
      end
      PRIME: begin
        count_d = '0;
        if (!enable_i) begin
          state_d = IDLE;
        end else if (level_q >= PrimeLvl) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
          count_d = '0;
        end else if (tick) begin
          count_d = '0;
          if (underrunSet) begin
            state_d = PRIME;
          end
        end else begin
          count_d = count_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      code_q     <= '0;
      update_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      code_q     <= code_d;
      update_q   <= update_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= rx_if.rx_data;
    end
  end

  assign dac_code_o   = code_q;
  assign dac_update_o = update_q;
  assign fifo_level_o = level_q;
  assign running_o    = (state_q == RUN);
  assign underrun_o   = underrun_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: expected DAC updates (code and cycle)
// are queued as stimulus is issued and checked by an independent monitor.
module tb_dac_sample_scheduler;
  localparam int D_W       = 8;
  localparam int DEPTH     = 8;
  localparam int DIV_W     = 16;
  localparam int PRIME_LVL = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [DIV_W-1:0] cfgDiv;
  logic             clearFlags;
  logic [D_W-1:0]   dacCode;
  logic             dacUpdate;
  logic [3:0]       fifoLevel;
  logic             running;
  logic             underrun;
  logic             overflow;

  dac_sample_scheduler_if #(.D_W(D_W)) rxIf ();

  dac_sample_scheduler #(
    .D_W(D_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .PRIME_LVL(PRIME_LVL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .rx_if        (rxIf),
    .cfg_div_i    (cfgDiv),
    .clear_flags_i(clearFlags),
    .dac_code_o   (dacCode),
    .dac_update_o (dacUpdate),
    .fifo_level_o (fifoLevel),
    .running_o    (running),
    .underrun_o   (underrun),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt++;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [7:0] code;
    int         cycle;
  } expT;
  expT expQ[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] data, input logic clr);
    enable        = en;
    rxIf.rx_valid = valid;
    rxIf.rx_data  = data;
    clearFlags    = clr;
    step();
    rxIf.rx_valid = 1'b0;
    clearFlags    = 1'b0;
  endtask

  task automatic expectUpdate(input logic [7:0] code, input int cyc);
    expT e;
    e.code  = code;
    e.cycle = cyc;
    expQ.push_back(e);
  endtask

  // Monitor: every dac_update pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    expT e;
    if (dacUpdate === 1'b1) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_update: got code 0x%0h at cycle %0d, required no update", dacCode, cycleCnt);
      end else begin
        e = expQ.pop_front();
        checkOutput("update_code", int'(dacCode), int'(e.code));
        checkOutput("update_cycle", cycleCnt, e.cycle);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int base;
    logic [7:0] words [9];
    rst           = 1'b1;
    enable        = 1'b0;
    cfgDiv        = '0;
    clearFlags    = 1'b0;
    rxIf.rx_valid = 1'b0;
    rxIf.rx_data  = '0;
    waitCycles(2);
    rst = 1'b0;

    checkOutput("reset_code", int'(dacCode), 0);
    checkOutput("reset_update", int'(dacUpdate), 0);
    checkOutput("reset_level", int'(fifoLevel), 0);
    checkOutput("reset_running", int'(running), 0);
    checkOutput("reset_underrun", int'(underrun), 0);
    checkOutput("reset_overflow", int'(overflow), 0);

    // Prime and play, then underrun with clear_flags colliding
    cfgDiv = 16'd3;
    applyStimulus(1'b1, 1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h20, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h40, 1'b0);
    base = cycleCnt;
    expectUpdate(8'h10, base + 5);
    expectUpdate(8'h20, base + 9);
    expectUpdate(8'h30, base + 13);
    expectUpdate(8'h40, base + 17);
    checkOutput("t1_level_primed", int'(fifoLevel), 4);
    checkOutput("t1_running_prime", int'(running), 0);
    waitCycles(1);
    checkOutput("t1_running_run", int'(running), 1);
    waitCycles(19);
    checkOutput("t1_underrun_before", int'(underrun), 0);
    checkOutput("t1_level_empty", int'(fifoLevel), 0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("t1_underrun_priority", int'(underrun), 1);
    checkOutput("t1_running_after", int'(running), 0);
    checkOutput("t1_code_held", int'(dacCode), 8'h40);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("t1_underrun_cleared", int'(underrun), 0);
    checkOutput("t1_overflow_cleared", int'(overflow), 0);

    // Overflow while idle, then drain at one code per cycle
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
    checkOutput("t2_level_full", int'(fifoLevel), 8);
    checkOutput("t2_overflow_before", int'(overflow), 0);
    applyStimulus(1'b0, 1'b1, 8'h09, 1'b0);
    checkOutput("t2_level_drop", int'(fifoLevel), 8);
    checkOutput("t2_overflow_set", int'(overflow), 1);
    cfgDiv = 16'd0;
    base = cycleCnt;
    for (int k = 0; k < 8; k++) expectUpdate(8'(k + 1), base + 3 + k);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(10);
    checkOutput("t2_underrun", int'(underrun), 1);
    checkOutput("t2_overflow_kept", int'(overflow), 1);
    checkOutput("t2_code_last", int'(dacCode), 8'h08);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("t2_flags_cleared", int'({underrun, overflow}), 0);

    // Full FIFO with write coincident with a pop
    cfgDiv = 16'd3;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'(8'h51 + i), 1'b0);
    checkOutput("t3_level_full", int'(fifoLevel), 8);
    base = cycleCnt;
    for (int k = 0; k < 9; k++) expectUpdate(8'(8'h51 + k), base + 6 + 4 * k);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(4);
    applyStimulus(1'b1, 1'b1, 8'h59, 1'b0);
    checkOutput("t3_level_push_pop", int'(fifoLevel), 8);
    checkOutput("t3_overflow_none", int'(overflow), 0);
    waitCycles(36);
    checkOutput("t3_underrun", int'(underrun), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Disable mid-run, then re-enable
    cfgDiv = 16'd9;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h61 + i), 1'b0);
    checkOutput("t4_level_loaded", int'(fifoLevel), 5);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(6);
    checkOutput("t4_running", int'(running), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("t4_running_off", int'(running), 0);
    checkOutput("t4_level_kept", int'(fifoLevel), 5);
    waitCycles(12);
    checkOutput("t4_level_idle", int'(fifoLevel), 5);
    checkOutput("t4_code_held", int'(dacCode), 8'h59);
    base = cycleCnt;
    expectUpdate(8'h61, base + 12);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(12);
    checkOutput("t4_level_after_pop", int'(fifoLevel), 4);
    checkOutput("t4_running_again", int'(running), 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset mid-operation
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6_pre_level", int'(fifoLevel), 0);
    cfgDiv   = 16'd0;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'hA5; words[5] = 8'h66;
    words[6] = 8'h77; words[7] = 8'h88; words[8] = 8'h99;
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, words[i], 1'b0);
    base = cycleCnt;
    for (int k = 0; k < 5; k++) expectUpdate(words[k], base + 3 + k);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitCycles(6);
    checkOutput("t6_code_before", int'(dacCode), 8'hA5);
    checkOutput("t6_level_before", int'(fifoLevel), 3);
    checkOutput("t6_overflow_before", int'(overflow), 1);
    rst = 1'b1;
    step();
    rst    = 1'b0;
    enable = 1'b0;
    checkOutput("t6_code_reset", int'(dacCode), 0);
    checkOutput("t6_update_reset", int'(dacUpdate), 0);
    checkOutput("t6_level_reset", int'(fifoLevel), 0);
    checkOutput("t6_running_reset", int'(running), 0);
    checkOutput("t6_flags_reset", int'({underrun, overflow}), 0);
    waitCycles(5);
    checkOutput("t6_level_settled", int'(fifoLevel), 0);
    checkOutput("t6_running_settled", int'(running), 0);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
- Sits between the serial-to-parallel receiver and the R2R DAC code register.
- Buffers received words in a small FIFO and releases them to the DAC at a programmable, fixed sample rate.
- Primes the FIFO before playback and detects underrun and overflow.
- Turns bursty serial arrivals into a jitter-free DAC update stream.

Parameters:
- D_W, 8, DAC code / received word width
- DEPTH, 8, FIFO depth in words; power of two, >= 2
- DIV_W, 16, width of sample-period divider
- PRIME_LVL, 4, FIFO level required before playback starts; 1..DEPTH

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  playback enable; level-sensitive
- rx_data  in  D_W  word from deserializer
- rx_valid  in  1  one-cycle strobe, rx_data valid
- cfg_div  in  DIV_W  sample period minus one, in clk cycles
- clear_flags  in  1  one-cycle strobe, clears sticky flags
- dac_code  out  D_W  registered code driving the R2R ladder
- dac_update  out  1  one-cycle pulse, dac_code changed this cycle
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- running  out  1  high while in RUN
- underrun  out  1  sticky, tick found FIFO empty
- overflow  out  1  sticky, rx word dropped because FIFO full

Behaviour:
- Reset (rst=1 at posedge) clears FIFO pointers (level=0), divider counter=0, state=IDLE.
- Reset values: dac_code=0, dac_update=0, running=0, underrun=0, overflow=0.
- Reset mid-playback discards FIFO contents; no dac_update is issued.
- FIFO write: on rx_valid, rx_data is written if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
- FIFO full-drop: otherwise the word is dropped and overflow is set.
- FIFO accepts writes in every state.
- FIFO pop occurs only on a sample tick in RUN with level>0.
- fifo_level is registered: it reflects writes/pops of the previous edge. Simultaneous push+pop leaves it unchanged.
- Divider: counter runs only in RUN. tick = (counter==cfg_div).
  - On tick the counter resets to 0; otherwise it increments.
  - Period is cfg_div+1 cycles. cfg_div=0 gives a tick every cycle.
  - cfg_div is compared live; if it is lowered below the counter value, the counter runs to wrap at 2^DIV_W-1, then 0. Software must change cfg_div only in IDLE.
- FSM states IDLE, PRIME, RUN:
  - IDLE: running=0, counter held 0. enable=1 -> PRIME.
  - PRIME: counter held 0. level>=PRIME_LVL -> RUN (counter=0). enable=0 -> IDLE.
  - RUN: running=1. On tick with level>0: dac_code <= FIFO head at that edge, dac_update=1 the following cycle only.
  - RUN, tick with level==0: underrun set, dac_code held, no dac_update, -> PRIME (counter=0).
  - RUN, enable=0: -> IDLE next edge; a tick in that same cycle is ignored; dac_code held.
- Latency:
  - First tick after entering RUN: cfg_div+1 cycles after the transition edge.
  - dac_code is valid the same cycle dac_update is high.
- Flags: set has priority over clear_flags in the same cycle. Flags are never cleared by enable.
- dac_code holds its last value in IDLE/PRIME; it is never reset except by rst.

Test Plan:
- Prime and play: cfg_div=3, PRIME_LVL=4, enable=1, push 0x10,0x20,0x30,0x40 -> RUN after 4th write is counted. dac_update every 4 cycles with codes 0x10,0x20,0x30,0x40. Then underrun=1, state PRIME, dac_code stays 0x40.
- Overflow: enable=0, push 9 words 0x01..0x09 -> fifo_level=8, overflow=1, word 0x09 dropped. Enable, cfg_div=0 -> codes 0x01..0x08 on 8 consecutive cycles.
- Full with simultaneous pop: RUN, level=8, rx_valid coincident with tick -> word accepted, level stays 8, overflow stays 0.
- Disable mid-run: RUN, cfg_div=9, level=5, enable=0 at counter=5 -> IDLE, running=0, level=5 retained, no further dac_update. Re-enable -> immediate PRIME->RUN (level>=4), first update 10 cycles later.
- Flag priority: underrun event and clear_flags in the same cycle -> underrun=1. clear_flags alone next cycle -> underrun=0, overflow=0.
- Reset mid-operation: RUN, dac_code=0xA5, level=3, rst=1 one cycle -> dac_code=0, level=0, IDLE, all flags 0, no dac_update pulse.
